// File: rtl/dac_window_sequencer.sv
// Window-state sequencer for the DAC_advance datapath: tracks consecutive qualified
// windows up to DAC_stop_max, then fires a stimulus pulse followed by a refractory lockout.
module dac_window_sequencer #(
  parameter int CW = 32,
  parameter int TW = 16
) (
  input  logic          dataclk,
  input  logic          reset,
  input  logic          sample_strobe,
  input  logic          enable,
  input  logic          DAC_advance,
  input  logic [CW-1:0] DAC_stop_max,
  input  logic [TW-1:0] stim_width,
  input  logic [TW-1:0] refractory,
  input  logic          clear_count,
  output logic [CW-1:0] DAC_fsm_state_counter,
  output logic [1:0]    fsm_state,
  output logic          stim_out,
  output logic          stim_pulse,
  output logic [TW-1:0] stim_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    STIM    = 2'd2,
    REFRACT = 2'd3
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] timer_q;
  logic          stim_out_q;
  logic          stim_pulse_q;
  logic [TW-1:0] count_q;

  logic          trigger;
  logic [TW-1:0] count_d;
  logic [TW-1:0] width_m1;

  // NOTE: always_comb with a default for every output first, so no latch can be inferred.
  always_comb begin
    trigger  = 1'b0;
    count_d  = count_q;
    width_m1 = '0;
    if (stim_width != '0) width_m1 = stim_width - TW'(1);
    if (sample_strobe && state_q == TRACK && enable && DAC_advance &&
        cnt_q >= DAC_stop_max)
      trigger = 1'b1;
    // A clear wins over a coincident increment; the count saturates rather than wrapping.
    if (clear_count)
      count_d = '0;
    else if (trigger && count_q != '1)
      count_d = count_q + TW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples the
  // pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge dataclk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      stim_out_q   <= 1'b0;
      stim_pulse_q <= 1'b0;
      count_q      <= '0;
    end else begin
      stim_pulse_q <= 1'b0;
      count_q      <= count_d;
      if (sample_strobe) begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (enable && DAC_advance) begin
              state_q <= TRACK;
              cnt_q   <= CW'(1);
            end
          end
          TRACK: begin
            if (!enable || !DAC_advance) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (trigger) begin
              state_q      <= STIM;
              cnt_q        <= '0;
              timer_q      <= width_m1;
              stim_out_q   <= 1'b1;
              stim_pulse_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          STIM: begin
            // The pulse always runs its full width; enable and DAC_advance are ignored here.
            if (timer_q == '0) begin
              stim_out_q <= 1'b0;
              if (refractory != '0) begin
                state_q <= REFRACT;
                timer_q <= refractory - TW'(1);
              end else begin
                state_q <= IDLE;
              end
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          REFRACT: begin
            if (timer_q == '0) state_q <= IDLE;
            else               timer_q <= timer_q - TW'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign DAC_fsm_state_counter = cnt_q;
  assign fsm_state             = state_q;
  assign stim_out              = stim_out_q;
  assign stim_pulse            = stim_pulse_q;
  assign stim_count            = count_q;

endmodule

// File: tb/tb_dac_window_sequencer.sv
// Bench for dac_window_sequencer: directed scenarios plus randomized traffic, all compared
// every cycle against a strobe-level behavioural model of the window/stimulus rules.
module tb_dac_window_sequencer;

  localparam int CW = 32;
  localparam int TW = 4;

  logic          dataclk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_strobe = 1'b0;
  logic          enable = 1'b0;
  logic          DAC_advance = 1'b0;
  logic [CW-1:0] DAC_stop_max = '0;
  logic [TW-1:0] stim_width = '0;
  logic [TW-1:0] refractory = '0;
  logic          clear_count = 1'b0;
  logic [CW-1:0] DAC_fsm_state_counter;
  logic [1:0]    fsm_state;
  logic          stim_out;
  logic          stim_pulse;
  logic [TW-1:0] stim_count;

  dac_window_sequencer #(.CW(CW), .TW(TW)) dut (
    .dataclk               (dataclk),
    .reset                 (reset),
    .sample_strobe         (sample_strobe),
    .enable                (enable),
    .DAC_advance           (DAC_advance),
    .DAC_stop_max          (DAC_stop_max),
    .stim_width            (stim_width),
    .refractory            (refractory),
    .clear_count           (clear_count),
    .DAC_fsm_state_counter (DAC_fsm_state_counter),
    .fsm_state             (fsm_state),
    .stim_out              (stim_out),
    .stim_pulse            (stim_pulse),
    .stim_count            (stim_count)
  );

  always #5 dataclk = ~dataclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 tracking, 2 stimulating, 3 locked out; "left" = strobes remaining.
  int      m_mode = 0;
  longint  m_cnt = 0;
  int      m_left = 0;
  int      m_count = 0;
  bit      m_pulse = 0;
  int      max_count = (1 << TW) - 1;

  task automatic model_step();
    bit inc = 0;
    m_pulse = 0;
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_left = 0; m_count = 0;
      return;
    end
    if (sample_strobe) begin
      if (m_mode == 0) begin
        if (enable && DAC_advance) begin m_mode = 1; m_cnt = 1; end
      end else if (m_mode == 1) begin
        if (!enable || !DAC_advance) begin
          m_mode = 0; m_cnt = 0;
        end else if (m_cnt >= longint'(DAC_stop_max)) begin
          m_mode = 2; m_cnt = 0; m_pulse = 1; inc = 1;
          m_left = (stim_width == 0) ? 1 : int'(stim_width);
        end else begin
          m_cnt++;
        end
      end else if (m_mode == 2) begin
        m_left--;
        if (m_left == 0) begin
          if (refractory != 0) begin m_mode = 3; m_left = int'(refractory); end
          else m_mode = 0;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    end
    if (clear_count) m_count = 0;
    else if (inc && m_count < max_count) m_count++;
  endtask

  int n_pulse = 0;
  int n_stim = 0;
  int n_refr = 0;

  task automatic tick();
    @(posedge dataclk);
    model_step();
    #1;
    check("state", 64'(fsm_state), 64'(m_mode));
    check("counter", 64'(DAC_fsm_state_counter), 64'(m_cnt));
    check("stim_out", 64'(stim_out), 64'(m_mode == 2));
    check("stim_pulse", 64'(stim_pulse), 64'(m_pulse));
    check("stim_count", 64'(stim_count), 64'(m_count));
    if (stim_pulse) n_pulse++;
  endtask

  task automatic do_strobe(input int gap);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    if (fsm_state == 2'd2) n_stim++;
    if (fsm_state == 2'd3) n_refr++;
    repeat (gap - 1) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_stats();
    n_pulse = 0; n_stim = 0; n_refr = 0;
  endtask

  initial begin
    logic [CW-1:0] seq [6];
    int guard;

    tick();
    check("reset_state", 64'(fsm_state), 0);
    check("reset_stim_out", 64'(stim_out), 0);
    do_reset();

    // Full qualification
    enable = 1; DAC_advance = 1; DAC_stop_max = 5; stim_width = 3; refractory = 4;
    clear_stats();
    for (int i = 0; i < 6; i++) begin
      do_strobe(4);
      seq[i] = DAC_fsm_state_counter;
    end
    for (int i = 0; i < 5; i++) check("fq_counter_seq", 64'(seq[i]), 64'(i + 1));
    check("fq_counter_zero", 64'(seq[5]), 0);
    check("fq_entered_stim", 64'(fsm_state), 2);
    for (int i = 0; i < 7; i++) do_strobe(4);
    check("fq_pulses", 64'(n_pulse), 1);
    check("fq_stim_strobes", 64'(n_stim), 3);
    check("fq_refract_strobes", 64'(n_refr), 4);
    check("fq_final_idle", 64'(fsm_state), 0);
    check("fq_stim_count", 64'(stim_count), 1);

    // Break in track at counter 3
    DAC_stop_max = 10; clear_stats();
    repeat (3) do_strobe(2);
    check("brk_counter3", 64'(DAC_fsm_state_counter), 3);
    DAC_advance = 0;
    do_strobe(2);
    check("brk_idle", 64'(fsm_state), 0);
    check("brk_counter0", 64'(DAC_fsm_state_counter), 0);
    DAC_advance = 1;
    do_strobe(2);
    check("brk_restart", 64'(DAC_fsm_state_counter), 1);
    check("brk_no_pulse", 64'(n_pulse), 0);
    DAC_advance = 0;
    do_strobe(2);

    // Zero width and zero refractory
    DAC_advance = 1; DAC_stop_max = 1; stim_width = 0; refractory = 0; clear_stats();
    repeat (3) do_strobe(3);
    check("zw_stim_strobes", 64'(n_stim), 1);
    check("zw_direct_idle", 64'(fsm_state), 0);
    check("zw_no_refract", 64'(n_refr), 0);

    // Lowered stop mid-track
    DAC_stop_max = 10; stim_width = 2; refractory = 1;
    repeat (6) do_strobe(2);
    check("low_counter6", 64'(DAC_fsm_state_counter), 6);
    DAC_stop_max = 2;
    do_strobe(2);
    check("low_stim", 64'(fsm_state), 2);
    DAC_advance = 0;
    guard = 0;
    while (fsm_state != 2'd0 && guard < 10) begin do_strobe(2); guard++; end
    check("low_back_idle", 64'(fsm_state), 0);

    // Disable in TRACK, then in STIM, then reset mid-STIM
    DAC_advance = 1; DAC_stop_max = 10;
    repeat (2) do_strobe(2);
    enable = 0;
    do_strobe(2);
    check("dis_track_idle", 64'(fsm_state), 0);
    enable = 1; DAC_stop_max = 1; stim_width = 3; refractory = 0; clear_stats();
    repeat (2) do_strobe(2);
    enable = 0; DAC_advance = 0;
    repeat (3) do_strobe(2);
    check("dis_stim_full", 64'(n_stim), 3);
    check("dis_stim_idle", 64'(fsm_state), 0);
    enable = 1; DAC_advance = 1; stim_width = 5;
    repeat (2) do_strobe(2);
    check("rst_in_stim", 64'(stim_out), 1);
    reset = 1;
    tick();
    check("rst_stim_out", 64'(stim_out), 0);
    check("rst_state", 64'(fsm_state), 0);
    check("rst_count", 64'(stim_count), 0);
    reset = 0;

    // Saturation and clear
    DAC_stop_max = 0; stim_width = 1; refractory = 0;
    repeat (17) repeat (3) do_strobe(2);
    check("sat_hold", 64'(stim_count), 15);
    clear_stats();
    do_strobe(2);
    clear_count = 1;
    do_strobe(1);
    clear_count = 0;
    check("clr_with_trigger", 64'(stim_count), 0);
    check("clr_trigger_fired", 64'(n_pulse), 1);
    tick();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      sample_strobe = ($urandom_range(2) == 0);
      enable        = ($urandom_range(15) != 0);
      DAC_advance   = ($urandom_range(9) != 0);
      clear_count   = ($urandom_range(40) == 0);
      reset         = ($urandom_range(300) == 0);
      if ($urandom_range(30) == 0) DAC_stop_max = CW'($urandom_range(6));
      if ($urandom_range(30) == 0) stim_width   = TW'($urandom_range(4));
      if ($urandom_range(30) == 0) refractory   = TW'($urandom_range(3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
